controller_emulator_m: RTL and testbench
========================================

# controller_emulator_m

Device-side counterpart of the NES-style serial controller bus. It presents up to `NUM_CONTROLLERS` virtual controllers to an external host that drives a shared latch and a shared clock and samples one active-low data line per controller. Button states arrive in parallel from logic inside the FPGA, such as a USB/UART bridge or a test sequencer. The block oversamples the host lines on its own system clock and serialises a coherent 8-bit snapshot per controller, frame by frame.

## Interface
Parameters:
- `NUM_CONTROLLERS`, 2: number of emulated controllers sharing latch/clock.
- `SYNC_STAGES`, 2: synchroniser flops on `host_latch` and `host_clk`; minimum 2.

Ports:
- `clk`  input  1: system clock; must run at ≥8× the host controller-clock rate.
- `rst`  input  1: synchronous, active-high reset.
- `host_latch`  input  1: asynchronous; host parallel-load strobe, active high.
- `host_clk`  input  1: asynchronous; host shift clock, rising edge shifts.
- `controller_data_B_LIST`  output  NUM_CONTROLLERS: serial data per controller, active low (0 = pressed), registered.
- `buttons_in_LIST`  input  8*NUM_CONTROLLERS: byte per controller, 1 = pressed; bit 7 A, 6 B, 5 Select, 4 Start, 3 Up, 2 Down, 1 Left, 0 Right.
- `buttons_we`  input  1: single-cycle strobe; captures all of `buttons_in_LIST` into the shadow registers.
- `busy`  output  1: high in LOAD or SHIFT.
- `frame_done`  output  1: one-cycle pulse when the last bit (bit 0) is presented.

## Operation
- The synchroniser plus edge detector produce `latch_rise`, `latch_fall`, `clk_rise` and a synchronised `latch_level`.
- Each controller has an 8-bit shadow register and an 8-bit shift register. The shadow loads on `buttons_we`; the shift register loads only from the shadow.
- `controller_data_B` for each controller is `~shift[7]`.
- States:
  - **IDLE**: outputs hold the last value. `latch_rise` → LOAD.
  - **LOAD**: every cycle, shift ← shadow. `clk_rise` is ignored (the host pulses the clock during latch). `latch_fall` → SHIFT, with `bit_cnt`=0 and shift not reloaded that cycle, so bit 7 is presented.
  - **SHIFT**: on each `clk_rise`, shift ← {shift[6:0],1'b0} and `bit_cnt`++. When `bit_cnt` goes 6→7, pulse `frame_done` and → DONE.
  - **DONE**: further `clk_rise` events keep shifting zeros (data_B=1, released). `latch_rise` → LOAD.
- `latch_rise` in any state → LOAD. This restarts the frame with no `frame_done`.
- A full frame is 1 latch plus 7 clock rises and yields 8 bits, MSB (A) first.
- `bit_cnt` is 3 bits and saturates at 7; it never wraps.

## Timing
- Reset values:
  - `controller_data_B_LIST` all 1.
  - `busy` 0, `frame_done` 0, state IDLE.
  - shadow and shift registers 0, `bit_cnt` 0.
- Reset mid-frame returns to IDLE immediately. The host sees released buttons until the next latch.
- Edge-to-output latency is SYNC_STAGES+1 `clk` cycles from a host pin edge to the `controller_data_B` update (3 with defaults). The 8× ratio guarantees the data is settled before the host's next sample.
- `buttons_we` timing:
  - In LOAD, the new value reaches the outputs the following cycle.
  - In the `latch_fall` cycle, it updates the shadow only, so the current frame keeps the old snapshot.
  - In SHIFT or DONE, it updates the shadow only.
- `latch_fall` and `clk_rise` in the same cycle: the latch is processed and the clock is ignored.
- `latch_rise` and `clk_rise` in the same cycle: the latch is processed.
- `frame_done` is asserted in the same cycle as the bit-0 output update.

## Structure
- Shared package `controller_pkg`:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - button bit-index constants (`BTN_A`=7 … `BTN_RIGHT`=0);
  - `BITS_PER_FRAME`=8.
  - The host-side interface imports the same button constants.
- Sub-module `sync_edge_m`: a SYNC_STAGES-deep synchroniser plus a registered previous value. It outputs `level`, `rise` and `fall`, and is instantiated once each for `host_latch` and `host_clk`.
- Per-controller shadow and shift registers live in a generate loop. The FSM and `bit_cnt` are shared.

## Test plan
- Reset, then `buttons_we` with controller 0 = 8'hA5 and controller 1 = 8'h3C, then a standard frame (latch, 7 clocks) → controller 0 data_B sequence 0,1,0,1,1,0,1,0 and controller 1 1,1,0,0,0,0,1,1. `frame_done` pulses once.
- Host clock pulses while latch is high (as the host block produces) → ignored; the first bit is still bit 7.
- `buttons_we` 8'hFF during SHIFT of an 8'h00 frame → current frame is all 1s on data_B; the next frame is all 0s.
- 10 clocks after the latch → bits 7..0 are followed by data_B=1 for the 3 extra clocks; exactly one `frame_done`.
- New latch after 3 clocks → restart at bit 7; no `frame_done` for the aborted frame.
- `rst` asserted after the 4th clock → next cycle data_B all 1, `busy`=0; the next full frame is correct.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared definitions for the NES-style controller emulator and its host-side counterpart.
// FSM state codes, button bit positions and the frame length.
package controller_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   localparam int BITS_PER_FRAME = 8;

   typedef logic [BITS_PER_FRAME-1:0] btn_byte_t;

   // Shift one bit towards the MSB.
   // Zeros fill in from the bottom, so a drained register reads as released.
   function automatic btn_byte_t shift_out(input btn_byte_t v);
      return {v[BITS_PER_FRAME-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/sync_edge_m.sv
// Multi-stage synchroniser for one asynchronous host pin.
// Also flags its synchronised rising and falling edges.
module sync_edge_m #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;

   // Synchroniser chain plus one-cycle-delayed copy of the synchronised level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], din};
         prev_r <= sync_r[STAGES-1];
      end
   end

   assign level = sync_r[STAGES-1];
   assign rise  = sync_r[STAGES-1] & ~prev_r;
   assign fall  = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/controller_emulator_m.sv
// Emulates NUM_CONTROLLERS serial game controllers on a shared host latch/clock bus.
// Button snapshots are shadowed, then serialised MSB (A) first on active-low data lines.
module controller_emulator_m
   import controller_pkg::*;
#(
   parameter int NUM_CONTROLLERS = 2,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          host_latch,
   input  logic                          host_clk,
   output logic [NUM_CONTROLLERS-1:0]    controller_data_B_LIST,
   input  logic [8*NUM_CONTROLLERS-1:0]  buttons_in_LIST,
   input  logic                          buttons_we,
   output logic                          busy,
   output logic                          frame_done
);

   logic latch_level, latch_rise, latch_fall;
   logic clk_level, clk_rise, clk_fall;
   logic unused_edges;

   logic [1:0] state_r, state_nxt;
   logic [2:0] cnt_r, cnt_nxt;
   logic       load_en, shift_en, done_nxt;
   logic       busy_r, frame_done_r;

   sync_edge_m #(.STAGES(SYNC_STAGES)) u_latch_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (host_latch),
      .level (latch_level),
      .rise  (latch_rise),
      .fall  (latch_fall)
   );

   sync_edge_m #(.STAGES(SYNC_STAGES)) u_clk_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (host_clk),
      .level (clk_level),
      .rise  (clk_rise),
      .fall  (clk_fall)
   );

   assign unused_edges = &{1'b0, latch_level, clk_level, clk_fall};

   // Next-state and shift control; a latch rise overrides everything, including a coincident clock rise.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      load_en   = 1'b0;
      shift_en  = 1'b0;
      done_nxt  = 1'b0;
      if (latch_rise) begin
         state_nxt = ST_LOAD;
         cnt_nxt   = 3'd0;
         load_en   = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
               // Host clock pulses during latch are ignored; bit 7 stays presented on fall.
               if (latch_fall) begin
                  state_nxt = ST_SHIFT;
                  cnt_nxt   = 3'd0;
               end else begin
                  load_en = 1'b1;
               end
            end
            ST_SHIFT: begin
               if (clk_rise) begin
                  shift_en = 1'b1;
                  cnt_nxt  = (cnt_r == 3'd7) ? 3'd7 : cnt_r + 3'd1;
                  if (cnt_r == 3'(BITS_PER_FRAME - 2)) begin
                     done_nxt  = 1'b1;
                     state_nxt = ST_DONE;
                  end else begin
                     state_nxt = ST_SHIFT;
                  end
               end else begin
                  shift_en = 1'b0;
               end
            end
            ST_DONE: begin
               if (clk_rise) begin
                  shift_en = 1'b1;
               end else begin
                  shift_en = 1'b0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               cnt_nxt   = 3'd0;
            end
         endcase
      end
   end

   // Shared FSM, bit counter and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 3'd0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         cnt_r        <= cnt_nxt;
         busy_r       <= (state_nxt == ST_LOAD) || (state_nxt == ST_SHIFT);
         frame_done_r <= done_nxt;
      end
   end

   assign busy       = busy_r;
   assign frame_done = frame_done_r;

   for (genvar g = 0; g < NUM_CONTROLLERS; g++) begin : g_ctrl
      btn_byte_t new_byte, shadow_r, shift_r, shift_nxt;
      logic      data_b_r;

      assign new_byte = buttons_in_LIST[BITS_PER_FRAME*g +: BITS_PER_FRAME];

      // While loading, a same-cycle write bypasses the shadow so it shows on the next cycle.
      always_comb begin
         shift_nxt = shift_r;
         if (load_en) begin
            shift_nxt = buttons_we ? new_byte : shadow_r;
         end else if (shift_en) begin
            shift_nxt = shift_out(shift_r);
         end else begin
            shift_nxt = shift_r;
         end
      end

      // Per-controller shadow, shift register and registered active-low data line.
      always_ff @(posedge clk) begin
         if (rst) begin
            shadow_r <= '0;
            shift_r  <= '0;
            data_b_r <= 1'b1;
         end else begin
            if (buttons_we) begin
               shadow_r <= new_byte;
            end
            shift_r  <= shift_nxt;
            data_b_r <= ~shift_nxt[BTN_A];
         end
      end

      assign controller_data_B_LIST[g] = data_b_r;
   end

endmodule

// File: tb/tb_controller_emulator_m.sv
// Randomised self-checking bench for controller_emulator_m.
// A frame-position model is compared every cycle, plus literal frame checks.
module tb_controller_emulator_m;

   localparam int N  = 2;
   localparam int SS = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           host_latch;
   logic           host_clk;
   logic           buttons_we;
   logic [8*N-1:0] buttons_in;
   logic [N-1:0]   data_b;
   logic           busy;
   logic           frame_done;

   int vectors     = 0;
   int miscompares = 0;
   int fd_count    = 0;
   bit rnd_we      = 1'b0;

   logic [N-1:0] samp [0:15];
   int           nsamp;

   // Model state: frame position instead of a shift register.
   localparam int M_IDLE = 0, M_LOAD = 1, M_SHIFT = 2, M_DONE = 3;
   logic [7:0]   m_shadow [N];
   logic [7:0]   m_snap   [N];
   int           m_mode;
   int           m_pos;
   logic         lh [0:7];
   logic         ch [0:7];
   logic [N-1:0] exp_b;
   logic         exp_busy;
   logic         exp_fd;
   bit           model_valid = 1'b0;

   controller_emulator_m #(.NUM_CONTROLLERS(N), .SYNC_STAGES(SS)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .host_latch             (host_latch),
      .host_clk               (host_clk),
      .controller_data_B_LIST (data_b),
      .buttons_in_LIST        (buttons_in),
      .buttons_we             (buttons_we),
      .busy                   (busy),
      .frame_done             (frame_done)
   );

   initial forever #5 clk = ~clk;

   // Reference model, updated on every rising edge from the pins the DUT sees.
   initial begin
      logic       lr, lf, cr;
      logic [7:0] nsh [N];
      forever begin
         @(posedge clk);
         exp_fd = 1'b0;
         if (rst) begin
            for (int i = 0; i < 8; i++) begin
               lh[i] = 1'b0;
               ch[i] = 1'b0;
            end
            for (int c = 0; c < N; c++) begin
               m_shadow[c] = 8'h00;
               m_snap[c]   = 8'h00;
            end
            m_mode = M_IDLE;
            m_pos  = 0;
         end else begin
            for (int i = 7; i > 0; i--) begin
               lh[i] = lh[i-1];
               ch[i] = ch[i-1];
            end
            lh[0] = host_latch;
            ch[0] = host_clk;
            lr = lh[SS] && !lh[SS+1];
            lf = !lh[SS] && lh[SS+1];
            cr = ch[SS] && !ch[SS+1];
            for (int c = 0; c < N; c++)
               nsh[c] = buttons_we ? buttons_in[8*c +: 8] : m_shadow[c];
            if (lr) begin
               m_mode = M_LOAD;
               m_pos  = 0;
               for (int c = 0; c < N; c++) m_snap[c] = nsh[c];
            end else if (m_mode == M_LOAD) begin
               if (lf) m_mode = M_SHIFT;
               else for (int c = 0; c < N; c++) m_snap[c] = nsh[c];
            end else if (m_mode == M_SHIFT && cr) begin
               m_pos = m_pos + 1;
               if (m_pos == 7) begin
                  exp_fd = 1'b1;
                  m_mode = M_DONE;
               end
            end else if (m_mode == M_DONE && cr) begin
               if (m_pos < 8) m_pos = m_pos + 1;
            end
            for (int c = 0; c < N; c++) m_shadow[c] = nsh[c];
         end
         for (int c = 0; c < N; c++)
            exp_b[c] = (m_pos < 8) ? ~m_snap[c][7-m_pos] : 1'b1;
         exp_busy    = (m_mode == M_LOAD) || (m_mode == M_SHIFT);
         model_valid = 1'b1;
      end
   end

   // Every-cycle compare against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (model_valid) begin
         vectors++;
         if ({data_b, busy, frame_done} !== {exp_b, exp_busy, exp_fd}) begin
            miscompares++;
            $display("FAIL cycle @%0t: data_b=%b busy=%b frame_done=%b, expected data_b=%b busy=%b frame_done=%b",
                     $time, data_b, busy, frame_done, exp_b, exp_busy, exp_fd);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_count++;
   end

   task automatic chk(input string name, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic wait_c(input int n);
      repeat (n) begin
         @(negedge clk);
         buttons_we = rnd_we && ($urandom_range(0, 5) == 0);
         buttons_in = 16'($urandom);
      end
   endtask

   task automatic write_btn(input logic [7:0] b0, input logic [7:0] b1);
      buttons_in = {b1, b0};
      buttons_we = 1'b1;
      wait_c(1);
      buttons_we = 1'b0;
   endtask

   task automatic latch_phase(input int pulses);
      host_latch = 1'b1;
      wait_c(4);
      for (int p = 0; p < pulses; p++) begin
         host_clk = 1'b1;
         wait_c(4);
         host_clk = 1'b0;
         wait_c(4);
      end
      host_latch = 1'b0;
      wait_c(5);
      samp[0] = data_b;
      nsamp   = 1;
   endtask

   task automatic clock_pulse();
      host_clk = 1'b1;
      wait_c(5);
      if (nsamp < 16) begin
         samp[nsamp] = data_b;
         nsamp++;
      end
      host_clk = 1'b0;
      wait_c(4);
   endtask

   // Streams are the expected data_B sequences, first bit in the MSB.
   task automatic chk_frame(input string name, input logic [7:0] s0, input logic [7:0] s1, input int n);
      logic e0, e1;
      for (int i = 0; i < n; i++) begin
         e0 = (i < 8) ? s0[7-i] : 1'b1;
         e1 = (i < 8) ? s1[7-i] : 1'b1;
         chk($sformatf("%s c0 bit%0d", name, i), int'(samp[i][0]), int'(e0));
         chk($sformatf("%s c1 bit%0d", name, i), int'(samp[i][1]), int'(e1));
      end
   endtask

   initial begin
      int fd0;
      rst = 1'b1; host_latch = 1'b0; host_clk = 1'b0; buttons_we = 1'b0; buttons_in = 16'h0000;
      wait_c(3);
      rst = 1'b0;
      wait_c(3);
      chk("reset data_b", int'(data_b), 3);
      chk("reset busy", int'(busy), 0);
      chk("reset frame_done", int'(frame_done), 0);

      // Standard frame.
      write_btn(8'hA5, 8'h3C);
      wait_c(2);
      fd0 = fd_count;
      latch_phase(0);
      repeat (7) clock_pulse();
      wait_c(4);
      chk_frame("t1", 8'b0101_1010, 8'b1100_0011, 8);
      chk("t1 frame_done count", fd_count - fd0, 1);
      chk("t1 busy after frame", int'(busy), 0);

      // Clock pulses during latch are ignored.
      fd0 = fd_count;
      latch_phase(2);
      repeat (7) clock_pulse();
      wait_c(4);
      chk_frame("t2", 8'b0101_1010, 8'b1100_0011, 8);
      chk("t2 frame_done count", fd_count - fd0, 1);

      // Write during SHIFT only affects the next frame.
      write_btn(8'h00, 8'h00);
      latch_phase(0);
      repeat (2) clock_pulse();
      write_btn(8'hFF, 8'hFF);
      repeat (5) clock_pulse();
      chk_frame("t3 current", 8'hFF, 8'hFF, 8);
      latch_phase(0);
      repeat (7) clock_pulse();
      chk_frame("t3 next", 8'h00, 8'h00, 8);

      // Extra clocks read as released, one frame_done.
      write_btn(8'hA5, 8'h3C);
      wait_c(4);
      fd0 = fd_count;
      latch_phase(0);
      repeat (10) clock_pulse();
      wait_c(4);
      chk_frame("t4", 8'b0101_1010, 8'b1100_0011, 11);
      chk("t4 frame_done count", fd_count - fd0, 1);

      // Aborted frame restarts at bit 7 without frame_done.
      fd0 = fd_count;
      latch_phase(0);
      repeat (3) clock_pulse();
      wait_c(4);
      chk("t5 no frame_done on abort", fd_count - fd0, 0);
      latch_phase(0);
      repeat (7) clock_pulse();
      wait_c(4);
      chk_frame("t5", 8'b0101_1010, 8'b1100_0011, 8);
      chk("t5 frame_done count", fd_count - fd0, 1);

      // Reset mid-frame.
      latch_phase(0);
      repeat (4) clock_pulse();
      rst = 1'b1;
      wait_c(1);
      rst = 1'b0;
      chk("t6 data_b after rst", int'(data_b), 3);
      chk("t6 busy after rst", int'(busy), 0);
      wait_c(3);
      write_btn(8'h81, 8'h7E);
      latch_phase(0);
      repeat (7) clock_pulse();
      chk_frame("t6", 8'b0111_1110, 8'b1000_0001, 8);

      // Randomised frames, writes at arbitrary times, occasional aborts and resets.
      rnd_we = 1'b1;
      for (int it = 0; it < 60; it++) begin
         latch_phase($urandom_range(0, 2));
         repeat ($urandom_range(0, 10)) clock_pulse();
         if ($urandom_range(0, 9) == 0) begin
            rst = 1'b1;
            wait_c(1);
            rst = 1'b0;
         end
         wait_c($urandom_range(1, 12));
      end
      rnd_we = 1'b0;
      wait_c(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
